// File: rtl/gf180mcu_fd_sc_mcu9t5v0__orcap_4.sv
// Per-lane glitch-filtered OR of A1/A2 with rising-edge event capture, sticky flags,
// a saturating event counter and a four-phase clear handshake. Scan: GF180MCU_FD_SC_MCU9T5V0_ORCAP_SCAN_EN.
module gf180mcu_fd_sc_mcu9t5v0__orcap_4 #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int FILT  = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  input  logic             E,
  input  logic             CLR,
`ifdef GF180MCU_FD_SC_MCU9T5V0_ORCAP_SCAN_EN
  input  logic             SE,
  input  logic             SI,
  output logic             SO,
`endif
  output logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] EV,
  output logic [WIDTH-1:0] STKY,
  output logic [CNT_W-1:0] CNT,
  output logic             CLR_ACK
);

  typedef enum logic [0:0] {RUN = 1'b0, ACK = 1'b1} state_e;

  localparam logic [3:0] FC_LAST = 4'(FILT - 1);
  localparam int         SUM_W   = CNT_W + 5;

  logic [WIDTH-1:0] z_r, ev_r, stky_r;
  logic [CNT_W-1:0] cnt_r;
  logic             clr_ack_r;
  state_e           state_r;
  logic [3:0]       fc_r [WIDTH];

  logic [WIDTH-1:0] raw_s, z_nxt_s, ev_set_s, stky_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             clr_ack_nxt_s;
  state_e           state_nxt_s;
  logic [3:0]       fc_nxt_s [WIDTH];
  logic [4:0]       pc_s;

  function automatic logic [4:0] popcount(input logic [WIDTH-1:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base, input logic [4:0] inc);
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] max;
    sum = SUM_W'(base) + SUM_W'(inc);
    max = SUM_W'({CNT_W{1'b1}});
    if (sum > max) begin
      return {CNT_W{1'b1}};
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

  // Per-lane filter: Z follows raw only after FILT consecutive mismatching enabled cycles
  always_comb begin
    z_nxt_s  = z_r;
    ev_set_s = '0;
    fc_nxt_s = fc_r;
    for (int i = 0; i < WIDTH; i++) begin
      raw_s[i] = A1[i] | A2[i];
      if (E) begin
        if (raw_s[i] != z_r[i]) begin
          if (fc_r[i] == FC_LAST) begin
            z_nxt_s[i]  = raw_s[i];
            fc_nxt_s[i] = 4'd0;
            ev_set_s[i] = raw_s[i];
          end else begin
            fc_nxt_s[i] = fc_r[i] + 4'd1;
          end
        end else begin
          fc_nxt_s[i] = 4'd0;
        end
      end else begin
        fc_nxt_s[i] = fc_r[i];
      end
    end
  end

  assign pc_s = popcount(ev_set_s);

  // Clear handshake; events on the clearing edge survive the clear
  always_comb begin
    state_nxt_s   = state_r;
    clr_ack_nxt_s = clr_ack_r;
    stky_nxt_s    = stky_r | ev_set_s;
    cnt_nxt_s     = sat_add(cnt_r, pc_s);
    case (state_r)
      RUN: begin
        if (CLR) begin
          state_nxt_s   = ACK;
          clr_ack_nxt_s = 1'b1;
          stky_nxt_s    = ev_set_s;
          cnt_nxt_s     = sat_add({CNT_W{1'b0}}, pc_s);
        end else begin
          state_nxt_s   = RUN;
          clr_ack_nxt_s = 1'b0;
        end
      end
      ACK: begin
        if (CLR) begin
          state_nxt_s   = ACK;
          clr_ack_nxt_s = 1'b1;
        end else begin
          state_nxt_s   = RUN;
          clr_ack_nxt_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s   = RUN;
        clr_ack_nxt_s = 1'b0;
      end
    endcase
  end

`ifdef GF180MCU_FD_SC_MCU9T5V0_ORCAP_SCAN_EN
  localparam int CH_N = 2 * WIDTH + CNT_W + 2;
  logic [CH_N-1:0] chain_s, shift_s;
  assign chain_s = {state_r, clr_ack_r, cnt_r, stky_r, z_r};
  assign shift_s = {chain_s[CH_N-2:0], SI};
  assign SO      = state_r;
`endif

  // State registers; EV and the filter counters hold while shifting
  always_ff @(posedge CLK) begin
    if (RST) begin
      z_r       <= '0;
      ev_r      <= '0;
      stky_r    <= '0;
      cnt_r     <= '0;
      clr_ack_r <= 1'b0;
      state_r   <= RUN;
      for (int i = 0; i < WIDTH; i++) fc_r[i] <= 4'd0;
`ifdef GF180MCU_FD_SC_MCU9T5V0_ORCAP_SCAN_EN
    end else if (SE) begin
      z_r       <= shift_s[0 +: WIDTH];
      stky_r    <= shift_s[WIDTH +: WIDTH];
      cnt_r     <= shift_s[2*WIDTH +: CNT_W];
      clr_ack_r <= shift_s[CH_N-2];
      state_r   <= state_e'(shift_s[CH_N-1]);
`endif
    end else begin
      z_r       <= z_nxt_s;
      ev_r      <= ev_set_s;
      stky_r    <= stky_nxt_s;
      cnt_r     <= cnt_nxt_s;
      clr_ack_r <= clr_ack_nxt_s;
      state_r   <= state_nxt_s;
      fc_r      <= fc_nxt_s;
    end
  end

  assign Z       = z_r;
  assign EV      = ev_r;
  assign STKY    = stky_r;
  assign CNT     = cnt_r;
  assign CLR_ACK = clr_ack_r;

endmodule
